// File: rtl/reg_file_ckpt.sv
// Rename-aware register file: 32 regs with busy/tag, ROB/CDB operand resolution, branch checkpoints.
// Define RF_CDB_FWD_EN to compile the same-cycle CDB bypass into the read path.
module reg_file_ckpt #(
    parameter int XLEN  = 32,
    parameter int TAGW  = 5,
    parameter int NRD   = 4,
    parameter int NCDB  = 2,
    parameter int NCKPT = 4,
    parameter int CW    = $clog2(NCKPT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic [NRD*5-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]  rd_val,
    output logic [NRD-1:0]       rd_rdy,
    output logic [NRD*TAGW-1:0]  rob_qtag,
    input  logic [NRD-1:0]       rob_qrdy,
    input  logic [NRD*XLEN-1:0]  rob_qval,
    input  logic                 cmt_flag,
    input  logic [4:0]           cmt_rd,
    input  logic [TAGW-1:0]      cmt_tag,
    input  logic [XLEN-1:0]      cmt_val,
    input  logic                 rnm_flag,
    input  logic [4:0]           rnm_rd,
    input  logic [TAGW-1:0]      rnm_tag,
    input  logic [NCDB-1:0]      cdb_flag,
    input  logic [NCDB*TAGW-1:0] cdb_tag,
    input  logic [NCDB*XLEN-1:0] cdb_val,
    input  logic                 ckpt_take,
    output logic [CW-1:0]        ckpt_id,
    output logic                 ckpt_full,
    input  logic                 ckpt_free,
    input  logic                 ckpt_restore,
    input  logic [CW-1:0]        ckpt_restore_id
);

    logic [XLEN-1:0] reg_val_q [32];
    logic [XLEN-1:0] reg_val_d [32];
    logic [31:0]     busy_q, busy_d;
    logic [TAGW-1:0] tag_q [32];
    logic [TAGW-1:0] tag_d [32];
    logic [31:0]     snap_busy_q [NCKPT];
    logic [31:0]     snap_busy_d [NCKPT];
    logic [TAGW-1:0] snap_tag_q [NCKPT][32];
    logic [TAGW-1:0] snap_tag_d [NCKPT][32];
    logic [CW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW:0]     count_q, count_d;

    logic rnm_en, cmt_en, free_en, take_en;

    assign ckpt_id   = tail_q;
    assign ckpt_full = (count_q == (CW+1)'(NCKPT));

`ifdef RF_CDB_FWD_EN
`else
    logic cdb_unused;
    assign cdb_unused = ^{cdb_flag, cdb_tag, cdb_val};
`endif

    // Operand resolution order: x0, architectural value, ROB result, CDB bypass, else tag.
    always_comb begin
        logic [4:0] r;
        r        = '0;
        rd_val   = '0;
        rd_rdy   = '0;
        rob_qtag = '0;
        for (int p = 0; p < NRD; p++) begin
            r = rd_addr[p*5 +: 5];
            rob_qtag[p*TAGW +: TAGW] = tag_q[r];
            if (r == 5'd0) begin
                rd_rdy[p] = 1'b1;
            end else if (!busy_q[r]) begin
                rd_val[p*XLEN +: XLEN] = reg_val_q[r];
                rd_rdy[p] = 1'b1;
            end else if (rob_qrdy[p]) begin
                rd_val[p*XLEN +: XLEN] = rob_qval[p*XLEN +: XLEN];
                rd_rdy[p] = 1'b1;
            end else begin
                rd_val[p*XLEN +: XLEN] = {{(XLEN-TAGW){1'b0}}, tag_q[r]};
`ifdef RF_CDB_FWD_EN
                for (int c = NCDB-1; c >= 0; c--) begin
                    if (cdb_flag[c] && cdb_tag[c*TAGW +: TAGW] == tag_q[r]) begin
                        rd_val[p*XLEN +: XLEN] = cdb_val[c*XLEN +: XLEN];
                        rd_rdy[p] = 1'b1;
                    end
                end
`endif
            end
        end
    end

    // Update strobes are single-cycle qualifiers sampled at the edge while rdy is high; no backpressure.
    always_comb begin
        logic [CW-1:0] off;
        reg_val_d   = reg_val_q;
        busy_d      = busy_q;
        tag_d       = tag_q;
        snap_busy_d = snap_busy_q;
        snap_tag_d  = snap_tag_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        off         = '0;
        cmt_en  = cmt_flag && (cmt_rd != 5'd0);
        rnm_en  = rnm_flag && (rnm_rd != 5'd0) && !flush && !ckpt_restore;
        free_en = ckpt_free && (count_q != '0) && !flush;
        take_en = ckpt_take && !ckpt_full && !flush && !ckpt_restore;

        if (rdy) begin
            if (cmt_en) reg_val_d[cmt_rd] = cmt_val;

            for (int i = 0; i < NCKPT; i++) begin
                off = CW'(i) - head_q;
                if (cmt_en && ({1'b0, off} < count_q) && snap_busy_q[i][cmt_rd] &&
                    snap_tag_q[i][cmt_rd] == cmt_tag) begin
                    snap_busy_d[i][cmt_rd] = 1'b0;
                    snap_tag_d[i][cmt_rd]  = '0;
                end
            end

            if (flush) begin
                busy_d  = '0;
                for (int k = 0; k < 32; k++) tag_d[k] = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else if (ckpt_restore) begin
                // Snapshot copy already carries this cycle's commit clear.
                busy_d = snap_busy_d[ckpt_restore_id];
                tag_d  = snap_tag_d[ckpt_restore_id];
                if (free_en) head_d = head_q + 1'b1;
                tail_d  = ckpt_restore_id;
                count_d = {1'b0, ckpt_restore_id - head_d};
            end else begin
                if (cmt_en && busy_q[cmt_rd] && tag_q[cmt_rd] == cmt_tag &&
                    !(rnm_en && rnm_rd == cmt_rd)) begin
                    busy_d[cmt_rd] = 1'b0;
                    tag_d[cmt_rd]  = '0;
                end
                if (rnm_en) begin
                    busy_d[rnm_rd] = 1'b1;
                    tag_d[rnm_rd]  = rnm_tag;
                end
                if (take_en) begin
                    snap_busy_d[tail_q] = busy_d;
                    snap_tag_d[tail_q]  = tag_d;
                    tail_d = tail_q + 1'b1;
                end
                if (free_en) head_d = head_q + 1'b1;
                count_d = count_q + {{CW{1'b0}}, take_en} - {{CW{1'b0}}, free_en};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                reg_val_q[k] <= '0;
                tag_q[k]     <= '0;
            end
            busy_q <= '0;
            for (int i = 0; i < NCKPT; i++) begin
                snap_busy_q[i] <= '0;
                for (int k = 0; k < 32; k++) snap_tag_q[i][k] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            reg_val_q   <= reg_val_d;
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            snap_busy_q <= snap_busy_d;
            snap_tag_q  <= snap_tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_file_ckpt.sv
// Directed bench for reg_file_ckpt: reads, rename/commit, checkpoint take/free/restore, flush, reset.
module tb_reg_file_ckpt;
    localparam int XLEN = 32, TAGW = 5, NRD = 4, NCDB = 2, NCKPT = 4, CW = 2;

    logic                 clk, rst, rdy, flush;
    logic [NRD*5-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]  rd_val;
    logic [NRD-1:0]       rd_rdy;
    logic [NRD*TAGW-1:0]  rob_qtag;
    logic [NRD-1:0]       rob_qrdy;
    logic [NRD*XLEN-1:0]  rob_qval;
    logic                 cmt_flag, rnm_flag;
    logic [4:0]           cmt_rd, rnm_rd;
    logic [TAGW-1:0]      cmt_tag, rnm_tag;
    logic [XLEN-1:0]      cmt_val;
    logic [NCDB-1:0]      cdb_flag;
    logic [NCDB*TAGW-1:0] cdb_tag;
    logic [NCDB*XLEN-1:0] cdb_val;
    logic                 ckpt_take, ckpt_full, ckpt_free, ckpt_restore;
    logic [CW-1:0]        ckpt_id, ckpt_restore_id;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    reg_file_ckpt dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .rd_addr(rd_addr), .rd_val(rd_val), .rd_rdy(rd_rdy),
        .rob_qtag(rob_qtag), .rob_qrdy(rob_qrdy), .rob_qval(rob_qval),
        .cmt_flag(cmt_flag), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
        .rnm_flag(rnm_flag), .rnm_rd(rnm_rd), .rnm_tag(rnm_tag),
        .cdb_flag(cdb_flag), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .ckpt_free(ckpt_free), .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic clear_pulses();
        flush = 0; cmt_flag = 0; rnm_flag = 0; ckpt_take = 0; ckpt_free = 0;
        ckpt_restore = 0; cdb_flag = '0; rob_qrdy = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [TAGW-1:0] t);
        rnm_flag = 1; rnm_rd = r; rnm_tag = t;
        tick();
    endtask

    task automatic set_commit(input logic [4:0] r, input logic [TAGW-1:0] t, input logic [XLEN-1:0] v);
        cmt_flag = 1; cmt_rd = r; cmt_tag = t; cmt_val = v;
    endtask

    // scoreboard: expected operand value queued, then popped against port 0
    task automatic read_chk(input string tag, input logic [4:0] r,
                            input logic [XLEN-1:0] exp_val, input logic exp_rdy);
        exp_q.push_back(exp_val);
        rd_addr = '0;
        rd_addr[4:0] = r;
        #1;
        check({tag, "_val"}, rd_val[XLEN-1:0], exp_q.pop_front());
        check({tag, "_rdy"}, {31'd0, rd_rdy[0]}, {31'd0, exp_rdy});
    endtask

    initial begin
        rst = 0; rdy = 1; rd_addr = '0; rob_qval = '0;
        cmt_rd = '0; cmt_tag = '0; cmt_val = '0; rnm_rd = '0; rnm_tag = '0;
        cdb_tag = '0; cdb_val = '0; ckpt_restore_id = '0;
        clear_pulses();
        repeat (2) @(posedge clk);
        #1;
        check("rst_id", {30'd0, ckpt_id}, 32'd0);
        check("rst_full", {31'd0, ckpt_full}, 32'd0);
        rst = 1;
        tick();

        read_chk("x5_reset", 5'd5, 32'd0, 1'b1);
        do_rename(5'd5, 5'd3);
        read_chk("x5_busy", 5'd5, 32'd3, 1'b0);
        check("x5_qtag", {27'd0, rob_qtag[4:0]}, 32'd3);

        // CDB bypass and ROB precedence, all combinational
        cdb_flag = 2'b10; cdb_tag = {5'd3, 5'd0}; cdb_val = {32'hAB, 32'h0};
`ifdef RF_CDB_FWD_EN
        read_chk("cdb1", 5'd5, 32'hAB, 1'b1);
        cdb_flag = 2'b11; cdb_tag = {5'd3, 5'd3}; cdb_val = {32'hAB, 32'hCD};
        read_chk("cdb_lowest", 5'd5, 32'hCD, 1'b1);
`else
        read_chk("cdb1_nofwd", 5'd5, 32'd3, 1'b0);
`endif
        cdb_flag = 2'b01; cdb_tag = {5'd0, 5'd4};
        read_chk("cdb_nomatch", 5'd5, 32'd3, 1'b0);
        rob_qrdy = 4'b0001; rob_qval[31:0] = 32'h55; cdb_flag = 2'b10; cdb_tag = {5'd3, 5'd0};
        read_chk("rob_first", 5'd5, 32'h55, 1'b1);
        clear_pulses();

        // commit and rename of the same register: rename wins
        set_commit(5'd5, 5'd3, 32'd7);
        do_rename(5'd5, 5'd9);
        read_chk("cmt_rnm", 5'd5, 32'd9, 1'b0);
        flush = 1;
        tick();
        read_chk("flush_val", 5'd5, 32'd7, 1'b1);

        // restore to a checkpoint
        do_rename(5'd1, 5'd1);
        check("take_id0", {30'd0, ckpt_id}, 32'd0);
        ckpt_take = 1;
        tick();
        check("take_id1", {30'd0, ckpt_id}, 32'd1);
        do_rename(5'd1, 5'd4);
        do_rename(5'd2, 5'd5);
        read_chk("x1_pre", 5'd1, 32'd4, 1'b0);
        ckpt_restore = 1; ckpt_restore_id = 2'd0;
        tick();
        read_chk("x1_rest", 5'd1, 32'd1, 1'b0);
        read_chk("x2_rest", 5'd2, 32'd0, 1'b1);
        check("rest_id", {30'd0, ckpt_id}, 32'd0);
        set_commit(5'd1, 5'd1, 32'h11);
        tick();
        read_chk("x1_cmt", 5'd1, 32'h11, 1'b1);

        // fill, overflow, free
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("full_at3", {31'd0, ckpt_full}, 32'd0);
            ckpt_take = 1;
            tick();
        end
        check("full_at4", {31'd0, ckpt_full}, 32'd1);
        ckpt_take = 1;
        tick();
        check("ovf_id", {30'd0, ckpt_id}, 32'd0);
        check("ovf_full", {31'd0, ckpt_full}, 32'd1);
        ckpt_free = 1; ckpt_take = 1;
        tick();
        check("free_take_full", {31'd0, ckpt_full}, 32'd0);
        ckpt_take = 1;
        tick();
        check("refill_id", {30'd0, ckpt_id}, 32'd1);
        check("refill_full", {31'd0, ckpt_full}, 32'd1);
        flush = 1;
        tick();
        check("flush_id", {30'd0, ckpt_id}, 32'd0);
        check("flush_full", {31'd0, ckpt_full}, 32'd0);

        // commit clears the matching snapshot entry
        do_rename(5'd3, 5'd2);
        ckpt_take = 1;
        tick();
        do_rename(5'd3, 5'd6);
        set_commit(5'd3, 5'd2, 32'h33);
        tick();
        read_chk("x3_live", 5'd3, 32'd6, 1'b0);
        ckpt_restore = 1; ckpt_restore_id = 2'd0;
        tick();
        read_chk("x3_rest", 5'd3, 32'h33, 1'b1);

        // commit in the same cycle as restore
        do_rename(5'd4, 5'd7);
        ckpt_take = 1;
        tick();
        do_rename(5'd4, 5'd8);
        ckpt_restore = 1; ckpt_restore_id = 2'd0;
        set_commit(5'd4, 5'd7, 32'h44);
        tick();
        read_chk("x4_rest_cmt", 5'd4, 32'h44, 1'b1);

        // freeze and x0
        rdy = 0;
        do_rename(5'd6, 5'd10);
        rdy = 1;
        read_chk("x6_frozen", 5'd6, 32'd0, 1'b1);
        do_rename(5'd0, 5'd3);
        read_chk("x0", 5'd0, 32'd0, 1'b1);
        check("x0_qtag", {27'd0, rob_qtag[4:0]}, 32'd0);

        // asynchronous reset mid-operation
        ckpt_take = 1;
        tick();
        check("pre_rst_id", {30'd0, ckpt_id}, 32'd1);
        rst = 0;
        #1;
        check("async_rst_id", {30'd0, ckpt_id}, 32'd0);
        read_chk("async_rst_x5", 5'd5, 32'd0, 1'b1);
        rst = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
